dhcp_msg_tx: RTL

Parametrised DHCP client message generator for DISCOVER, REQUEST and RELEASE. It builds a full BOOTP/DHCP payload: fixed header, chaddr, magic cookie, type-dependent options and zero padding. The payload is streamed byte-serially into the UDP transmit RAM path. It sits between the DHCP client control FSM and udp_tx, and uses the same request/ack/data-request handshake as the other UDP payload sources.

---
 rtl/dhcp_msg_tx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/dhcp_msg_tx.sv
// dhcp_msg_tx
//   Builds a DHCP DISCOVER / REQUEST / RELEASE client message (BOOTP header,
//   chaddr, magic cookie, type-dependent options, zero padding to PAD_LEN)
//   and streams it one byte per cycle into the UDP transmit RAM path.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            synchronous active-low reset
//   source_mac_addr  client MAC, emitted as chaddr (not latched)
//   xid              transaction ID, latched on request accept
//   msg_type         0 DISCOVER, 1 REQUEST, 2 RELEASE, 3 illegal (ignored)
//   req_ip           requested IP (option 50), latched on accept
//   server_ip        server identifier (option 54), latched on accept
//   ciaddr           client IP, latched on accept, sent only in RELEASE
//   dhcp_tx_req      level request to send one message
//   udp_tx_ack       UDP layer accepted the send request
//   udp_ram_data_req UDP layer ready for payload bytes
//   mac_send_end     frame transmission finished (one-cycle pulse)
//   dhcp_len         payload length (PAD_LEN once out of reset)
//   dhcp_wr          payload byte strobe
//   dhcp_tx_data     payload byte, zero when dhcp_wr is low
//   busy             high whenever a message is in progress
module dhcp_msg_tx #(
   parameter int unsigned PAD_LEN   = 300,
   parameter bit          BROADCAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [47:0] source_mac_addr,
   input  logic [31:0] xid,
   input  logic [1:0]  msg_type,
   input  logic [31:0] req_ip,
   input  logic [31:0] server_ip,
   input  logic [31:0] ciaddr,
   input  logic        dhcp_tx_req,
   input  logic        udp_tx_ack,
   input  logic        udp_ram_data_req,
   input  logic        mac_send_end,
   output logic [15:0] dhcp_len,
   output logic        dhcp_wr,
   output logic [7:0]  dhcp_tx_data,
   output logic        busy
);

   if ((PAD_LEN < 256) || (PAD_LEN > 1024)) begin : g_pad_len_check
      $error("dhcp_msg_tx: PAD_LEN must be within 256..1024");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_SEND, S_END} state_e;
   typedef enum logic [1:0] {MSG_DISCOVER, MSG_REQUEST, MSG_RELEASE, MSG_ILLEGAL} msg_e;

   localparam logic [15:0] LAST_CNT = 16'(PAD_LEN - 1);
   localparam logic [15:0] FLAGS    = BROADCAST ? 16'h8000 : 16'h0000;

   state_e      state_q, state_d;
   msg_e        type_q;
   logic [31:0] xid_q, req_ip_q, server_ip_q, ciaddr_q;
   logic [15:0] cnt_q, cnt_d;
   logic        mse_q;
   logic [15:0] dhcp_len_q;
   logic        wr_q, wr_d;
   logic [7:0]  data_q, data_d;
   logic [7:0]  byte_v;
   logic        accept;

   assign accept = (state_q == S_IDLE) && dhcp_tx_req && (msg_type != 2'd3);

   // State register plus the datapath registers that follow it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         type_q      <= MSG_DISCOVER;
         xid_q       <= '0;
         req_ip_q    <= '0;
         server_ip_q <= '0;
         ciaddr_q    <= '0;
         cnt_q       <= '0;
         mse_q       <= 1'b0;
         dhcp_len_q  <= '0;
         wr_q        <= 1'b0;
         data_q      <= '0;
      end else begin
         state_q    <= state_d;
         dhcp_len_q <= 16'(PAD_LEN);
         if (accept) begin
            type_q      <= msg_e'(msg_type);
            xid_q       <= xid;
            req_ip_q    <= req_ip;
            server_ip_q <= server_ip;
            ciaddr_q    <= ciaddr;
         end
         cnt_q  <= cnt_d;
         // Only a pulse seen while in END counts; the exit happens one cycle later
         mse_q  <= mac_send_end && (state_q == S_END);
         wr_q   <= wr_d;
         data_q <= data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)           state_d = S_START;
         S_START: if (udp_tx_ack)       state_d = S_WAIT;
         S_WAIT:  if (udp_ram_data_req) state_d = S_SEND;
         S_SEND:  if (cnt_q == LAST_CNT) state_d = S_END;
         S_END:   if (mse_q)            state_d = S_IDLE;
         default:                       state_d = S_IDLE;
      endcase
   end

   // Counter only advances while staying in SEND, so it reads 0 in END
   always_comb begin
      cnt_d = '0;
      if ((state_q == S_SEND) && (state_d == S_SEND)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Payload byte for the current counter value
   always_comb begin
      byte_v = '0;
      case (cnt_q)
         16'd0, 16'd1: byte_v = 8'h01;
         16'd2:        byte_v = 8'h06;
         16'd4:        byte_v = xid_q[31:24];
         16'd5:        byte_v = xid_q[23:16];
         16'd6:        byte_v = xid_q[15:8];
         16'd7:        byte_v = xid_q[7:0];
         16'd10:       byte_v = FLAGS[15:8];
         16'd11:       byte_v = FLAGS[7:0];
         16'd12:       byte_v = (type_q == MSG_RELEASE) ? ciaddr_q[31:24] : 8'h00;
         16'd13:       byte_v = (type_q == MSG_RELEASE) ? ciaddr_q[23:16] : 8'h00;
         16'd14:       byte_v = (type_q == MSG_RELEASE) ? ciaddr_q[15:8]  : 8'h00;
         16'd15:       byte_v = (type_q == MSG_RELEASE) ? ciaddr_q[7:0]   : 8'h00;
         16'd28:       byte_v = source_mac_addr[47:40];
         16'd29:       byte_v = source_mac_addr[39:32];
         16'd30:       byte_v = source_mac_addr[31:24];
         16'd31:       byte_v = source_mac_addr[23:16];
         16'd32:       byte_v = source_mac_addr[15:8];
         16'd33:       byte_v = source_mac_addr[7:0];
         16'd236:      byte_v = 8'h63;
         16'd237:      byte_v = 8'h82;
         16'd238:      byte_v = 8'h53;
         16'd239:      byte_v = 8'h63;
         16'd240:      byte_v = 8'h35;
         16'd241:      byte_v = 8'h01;
         16'd242: begin
            case (type_q)
               MSG_DISCOVER: byte_v = 8'h01;
               MSG_REQUEST:  byte_v = 8'h03;
               MSG_RELEASE:  byte_v = 8'h07;
               default:      byte_v = 8'h00;
            endcase
         end
         default: begin
            case (type_q)
               MSG_DISCOVER: begin
                  case (cnt_q)
                     16'd243: byte_v = 8'h37;
                     16'd244: byte_v = 8'h03;
                     16'd245: byte_v = 8'h01;
                     16'd246: byte_v = 8'h03;
                     16'd247: byte_v = 8'h06;
                     16'd248: byte_v = 8'hFF;
                     default: ;
                  endcase
               end
               MSG_REQUEST: begin
                  case (cnt_q)
                     16'd243: byte_v = 8'h32;
                     16'd244: byte_v = 8'h04;
                     16'd245: byte_v = req_ip_q[31:24];
                     16'd246: byte_v = req_ip_q[23:16];
                     16'd247: byte_v = req_ip_q[15:8];
                     16'd248: byte_v = req_ip_q[7:0];
                     16'd249: byte_v = 8'h36;
                     16'd250: byte_v = 8'h04;
                     16'd251: byte_v = server_ip_q[31:24];
                     16'd252: byte_v = server_ip_q[23:16];
                     16'd253: byte_v = server_ip_q[15:8];
                     16'd254: byte_v = server_ip_q[7:0];
                     16'd255: byte_v = 8'hFF;
                     default: ;
                  endcase
               end
               MSG_RELEASE: begin
                  case (cnt_q)
                     16'd243: byte_v = 8'h36;
                     16'd244: byte_v = 8'h04;
                     16'd245: byte_v = server_ip_q[31:24];
                     16'd246: byte_v = server_ip_q[23:16];
                     16'd247: byte_v = server_ip_q[15:8];
                     16'd248: byte_v = server_ip_q[7:0];
                     16'd249: byte_v = 8'hFF;
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
      endcase
   end

   // Output logic
   always_comb begin
      wr_d   = (state_q == S_SEND);
      data_d = wr_d ? byte_v : 8'h00;
      busy   = (state_q != S_IDLE);
   end

   assign dhcp_len     = dhcp_len_q;
   assign dhcp_wr      = wr_q;
   assign dhcp_tx_data = data_q;

endmodule
